fetch_ctrl: RTL and testbench

Sequencer for the RV64 fetch stage of the two-stage pipeline. Owns the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready request channel with a variable-latency response. Holds the returned word until decode accepts it, and discards stale responses after a redirect from execute/commit. Its output reproduces the existing fetch bus formats, so decode and the commit/difftest path stay unchanged.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types, widths and reset vector for the RV64 fetch sequencer.
package fetch_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FLUSH,
    ST_OUT
  } fetch_state_t;

  localparam int    FETCH_BUS_W      = 96;
  localparam int    FETCH_COMMIT_W   = 161;
  localparam addr_t DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// RV64 fetch sequencer: one outstanding imem request, holds the returned word
// until decode takes it, and drops responses made stale by a redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [63:0]               imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [31:0]               imem_rsp_data,
  output logic                      fetch_o_valid,
  input  logic                      fetch_o_ready,
  output logic [FETCH_BUS_W-1:0]    fetch_o_bus_info,
  output logic [FETCH_COMMIT_W-1:0] fetch_o_commit_info,
  output logic [63:0]               fetch_o_count
);

  fetch_state_t r_state;
  addr_t        r_pc;
  instr_t       r_instr;
  logic [63:0]  r_count;

  logic         w_idle;
  addr_t        w_pc_plus4;
  logic [159:0] w_commit_payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;

        ST_REQ: begin
          if (redirect_valid) r_pc <= redirect_pc;
          // An accepted request that coincides with a redirect is already stale.
          if (imem_req_ready) r_state <= redirect_valid ? ST_FLUSH : ST_WAIT;
        end

        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (redirect_valid) begin
              r_pc    <= redirect_pc;
              r_state <= ST_REQ;
            end else begin
              r_instr <= imem_rsp_data;
              r_state <= ST_OUT;
            end
          end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (redirect_valid) r_pc <= redirect_pc;
          if (imem_rsp_valid) r_state <= ST_REQ;
        end

        ST_OUT: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= ST_REQ;
          end else if (fetch_o_ready) begin
            r_pc    <= w_pc_plus4;
            r_count <= r_count + 64'd1;
            r_state <= ST_REQ;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_idle     = (r_state == ST_IDLE);
  assign w_pc_plus4 = r_pc + 64'd4;

  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = w_idle ? '0 : r_pc;

  // Redirect kills the offer in the same cycle, ahead of any decode handshake.
  assign fetch_o_valid = (r_state == ST_OUT) && !redirect_valid;

  assign fetch_o_bus_info    = w_idle ? '0 : {r_pc, r_instr};
  assign w_commit_payload    = w_idle ? '0 : {r_instr, w_pc_plus4, r_pc};
  assign fetch_o_commit_info = {fetch_o_valid, w_commit_payload};
  assign fetch_o_count       = r_count;

  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_state == ST_WAIT || r_state == ST_FLUSH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, checked by a
// scoreboard fed from an architectural PC/count model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [63:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         fetch_o_valid;
  logic         fetch_o_ready;
  logic [95:0]  fetch_o_bus_info;
  logic [160:0] fetch_o_commit_info;
  logic [63:0]  fetch_o_count;

  fetch_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_req_addr       (imem_req_addr),
    .imem_rsp_valid      (imem_rsp_valid),
    .imem_rsp_data       (imem_rsp_data),
    .fetch_o_valid       (fetch_o_valid),
    .fetch_o_ready       (fetch_o_ready),
    .fetch_o_bus_info    (fetch_o_bus_info),
    .fetch_o_commit_info (fetch_o_commit_info),
    .fetch_o_count       (fetch_o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          deliveries = 0;
  int          outstanding = 0;
  logic [63:0] arch_pc = DEFAULT_RESET_PC;
  logic [63:0] arch_cnt = '0;

  // memory model state
  bit          mem_pend = 1'b0;
  logic [63:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [160:0] act, input logic [160:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the memory returns the word for the accepted address.
  task automatic step(input bit rdy, input bit redir, input logic [63:0] rpc, input bit dready);
    @(posedge clk);
    #1;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    fetch_o_ready  = dready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  // Memory accepts requests on the handshake.
  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
    end
  end

  // Architectural model: the next instruction decode should see.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      arch_pc  <= DEFAULT_RESET_PC;
      arch_cnt  = '0;
      exp_q.delete();
      e.pc = DEFAULT_RESET_PC; e.ins = mem_word(DEFAULT_RESET_PC); e.cnt = '0;
      exp_q.push_back(e);
    end else if (redirect_valid) begin
      arch_pc <= redirect_pc;
      exp_q.delete();
      e.pc = redirect_pc; e.ins = mem_word(redirect_pc); e.cnt = arch_cnt;
      exp_q.push_back(e);
    end else if (fetch_o_valid && fetch_o_ready) begin
      arch_pc <= arch_pc + 64'd4;
      arch_cnt = arch_cnt + 64'd1;
      e.pc = arch_pc + 64'd4; e.ins = mem_word(arch_pc + 64'd4); e.cnt = arch_cnt;
      exp_q.push_back(e);
    end
  end

  // Monitor / scoreboard.
  logic        prev_fv, prev_fr, prev_redir, prev_reqv, prev_reqr;
  logic [95:0] prev_bus;
  logic [63:0] prev_cnt, prev_addr;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_fv = 0; prev_fr = 0; prev_redir = 0; prev_reqv = 0; prev_reqr = 0;
      prev_bus = '0; prev_cnt = '0; prev_addr = '0;
      outstanding = 0;
    end else begin
      if (imem_rsp_valid) outstanding--;
      if (redirect_valid) check("redirect_kills_valid", fetch_o_valid, 1'b0);
      if (imem_req_valid) begin
        check("req_addr_arch_pc", imem_req_addr, arch_pc);
        check("single_outstanding", outstanding, 0);
      end
      if (fetch_o_valid) begin
        check("scoreboard_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("bus_info", fetch_o_bus_info, {e.pc, e.ins});
          check("commit_info", fetch_o_commit_info, {1'b1, e.ins, e.pc + 64'd4, e.pc});
          if (fetch_o_ready) begin
            check("count_at_handshake", fetch_o_count, e.cnt);
            void'(exp_q.pop_front());
            deliveries++;
            $display("deliver pc=%h instr=%h count=%0d", e.pc, e.ins, e.cnt);
          end
        end
      end else begin
        check("commit_valid_bit", fetch_o_commit_info[160], 1'b0);
      end
      if (prev_fv && !prev_fr && !prev_redir) begin
        check("stall_valid_held", fetch_o_valid, !redirect_valid);
        check("stall_bus_stable", fetch_o_bus_info, prev_bus);
        check("stall_count_stable", fetch_o_count, prev_cnt);
      end
      if (prev_reqv && !prev_reqr && !prev_redir) begin
        check("req_valid_held", imem_req_valid, 1'b1);
        check("req_addr_held", imem_req_addr, prev_addr);
      end
      if (imem_req_valid && imem_req_ready) outstanding++;
      prev_fv = fetch_o_valid; prev_fr = fetch_o_ready; prev_redir = redirect_valid;
      prev_reqv = imem_req_valid; prev_reqr = imem_req_ready;
      prev_bus = fetch_o_bus_info; prev_cnt = fetch_o_count; prev_addr = imem_req_addr;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_req_addr"}, imem_req_addr, 64'd0);
    check({tag, "_fetch_valid"}, fetch_o_valid, 1'b0);
    check({tag, "_bus"}, fetch_o_bus_info, 96'd0);
    check({tag, "_commit"}, fetch_o_commit_info, 161'd0);
    check({tag, "_count"}, fetch_o_count, 64'd0);
  endtask

  localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

  initial begin
    bit          r_rdy, r_redir, r_dr;
    logic [63:0] r_pc;
    rst_n = 1'b0;
    redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = '0; fetch_o_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Release reset: one IDLE cycle, then REQ at the reset PC.
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");
    step(1, 0, 0, 0); @(negedge clk);
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, PC0);
    step(1, 0, 0, 0); @(negedge clk);
    check("wait_not_valid", fetch_o_valid, 1'b0);
    step(1, 0, 0, 0); @(negedge clk);
    check("first_valid_n2", fetch_o_valid, 1'b1);
    check("first_bus", fetch_o_bus_info, {PC0, mem_word(PC0)});
    check("first_next_pc", fetch_o_commit_info[127:64], PC0 + 64'd4);
    repeat (4) step(1, 0, 0, 0);
    @(negedge clk);
    check("stall_count_zero", fetch_o_count, 64'd0);
    step(1, 0, 0, 1); @(negedge clk);
    check("consume_valid", fetch_o_valid, 1'b1);

    // Redirect in WAIT, stale response three cycles after acceptance.
    lat_min = 3; lat_max = 3;
    step(1, 0, 0, 0); @(negedge clk);
    check("second_req_addr", imem_req_addr, PC0 + 64'd4);
    check("count_after_consume", fetch_o_count, 64'd1);
    step(0, 1, 64'h8000_1000, 0); @(negedge clk);
    repeat (2) begin
      step(0, 0, 0, 0); @(negedge clk);
      check("stale_not_presented", fetch_o_valid, 1'b0);
    end
    lat_min = 1; lat_max = 1;
    step(1, 0, 0, 0); @(negedge clk);
    check("redirect_req_addr", imem_req_addr, 64'h8000_1000);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); @(negedge clk);
    check("redirect_delivered", fetch_o_bus_info, {64'h8000_1000, mem_word(64'h8000_1000)});

    // Redirect coincident with the decode handshake.
    step(1, 1, 64'h8000_2000, 1); @(negedge clk);
    check("coincident_valid_low", fetch_o_valid, 1'b0);
    step(0, 0, 0, 0); @(negedge clk);
    check("coincident_count", fetch_o_count, 64'd1);
    check("coincident_req_addr", imem_req_addr, 64'h8000_2000);

    // Memory not ready, redirect on the second stalled cycle.
    step(0, 1, 64'h8000_3000, 0); @(negedge clk);
    check("held_addr_c2", imem_req_addr, 64'h8000_2000);
    step(0, 0, 0, 0); @(negedge clk);
    check("redirected_addr_c3", imem_req_addr, 64'h8000_3000);
    step(0, 0, 0, 0); @(negedge clk);
    check("redirected_addr_c4", imem_req_addr, 64'h8000_3000);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1); @(negedge clk);
    check("after_hold_delivered", fetch_o_bus_info[95:32], 64'h8000_3000);

    // PC wrap at the top of the address space.
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0); @(negedge clk);
    check("wrap_count_before", fetch_o_count, 64'd2);
    step(1, 0, 0, 0); @(negedge clk);
    check("wrap_req_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1); @(negedge clk);
    check("wrap_next_pc", fetch_o_commit_info[127:64], 64'd0);
    lat_min = 3; lat_max = 3;
    step(1, 0, 0, 0); @(negedge clk);
    check("wrap_req_zero", imem_req_addr, 64'd0);
    check("wrap_count_after", fetch_o_count, 64'd3);

    // Asynchronous reset while waiting for the response.
    step(1, 0, 0, 0);
    rst_n = 1'b0;
    mem_pend = 1'b0;
    #1;
    check_all_zero("async_reset");

    @(posedge clk); #1 rst_n = 1'b1;
    lat_min = 1; lat_max = 4;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); @(negedge clk);
    check("post_reset_req_addr", imem_req_addr, PC0);
    check("post_reset_count", fetch_o_count, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      r_rdy   = ($urandom_range(99) < 70);
      r_redir = ($urandom_range(99) < 8);
      r_dr    = ($urandom_range(99) < 60);
      r_pc    = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                         : ({$urandom, $urandom} & ~64'h3);
      step(r_rdy, r_redir, r_pc, r_dr);
    end
    step(0, 0, 0, 0); @(negedge clk);
    check("final_count", fetch_o_count, arch_cnt);
    check("random_progress", (deliveries > 20), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
